// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The unit takes an op from start/alucontrol/src_* when it is idle, and stall stays high until it can retire.
interface hilo_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [4:0]        alucontrol;
  logic              flush;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        state_dbg;

  modport master (
    output start, alucontrol, flush, src_a, src_b,
    input  stall, done, hi_o, lo_o, state_dbg
  );

  modport slave (
    input  start, alucontrol, flush, src_a, src_b,
    output stall, done, hi_o, lo_o, state_dbg
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for MIPS-style MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// The multiply has a fixed latency. The divide is restoring radix-2 and takes one bit per cycle.
module hilo_muldiv_unit #(
  parameter int         DATA_W     = 32,
  parameter int         MUL_LAT    = 2,
  parameter logic [4:0] ALU_MULT   = 5'd16,
  parameter logic [4:0] ALU_MULTU  = 5'd17,
  parameter logic [4:0] ALU_DIV    = 5'd18,
  parameter logic [4:0] ALU_DIVU   = 5'd19,
  parameter logic [4:0] ALU_MTHI   = 5'd20,
  parameter logic [4:0] ALU_MTLO   = 5'd21
) (
  input  logic          clk,
  input  logic          resetn,
  hilo_muldiv_if.slave  md
);

  localparam int CNT_W = $clog2((DATA_W > MUL_LAT) ? DATA_W : MUL_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, rem_q;
  logic              signed_q, neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              is_mul, is_div, md_op;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;

  assign is_mul = (md.alucontrol == ALU_MULT) || (md.alucontrol == ALU_MULTU);
  assign is_div = (md.alucontrol == ALU_DIV)  || (md.alucontrol == ALU_DIVU);
  assign md_op  = md.start & (is_mul | is_div);

  assign a_neg = (md.alucontrol == ALU_DIV) & md.src_a[DATA_W-1];
  assign b_neg = (md.alucontrol == ALU_DIV) & md.src_b[DATA_W-1];
  assign abs_a = a_neg ? (DATA_W'(0) - md.src_a) : md.src_a;
  assign abs_b = b_neg ? (DATA_W'(0) - md.src_b) : md.src_b;

  // op_a_q doubles as the dividend/quotient shift register during DIV.
  logic [DATA_W:0]   rem_shift, rem_diff;
  logic [DATA_W-1:0] rem_d, quo_d, rem_fix, quo_fix;

  assign rem_shift = {rem_q, op_a_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, op_b_q};
  assign rem_d     = rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  assign quo_d     = {op_a_q[DATA_W-2:0], ~rem_diff[DATA_W]};
  assign quo_fix   = neg_quo_q ? (DATA_W'(0) - quo_d) : quo_d;
  assign rem_fix   = neg_rem_q ? (DATA_W'(0) - rem_d) : rem_d;

  logic [2*DATA_W-1:0] ext_a, ext_b, prod;

  assign ext_a = signed_q ? {{DATA_W{op_a_q[DATA_W-1]}}, op_a_q} : {{DATA_W{1'b0}}, op_a_q};
  assign ext_b = signed_q ? {{DATA_W{op_b_q[DATA_W-1]}}, op_b_q} : {{DATA_W{1'b0}}, op_b_q};
  assign prod  = ext_a * ext_b;

  assign md.stall     = resetn & (((state_q == S_IDLE) & md_op & ~md.flush) |
                                  (state_q == S_MUL) | (state_q == S_DIV));
  assign md.done      = (state_q == S_DONE);
  assign md.hi_o      = hi_q;
  assign md.lo_o      = lo_q;
  assign md.state_dbg = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md.start && !md.flush) begin
            if (is_mul) begin
              op_a_q   <= md.src_a;
              op_b_q   <= md.src_b;
              signed_q <= (md.alucontrol == ALU_MULT);
              cnt_q    <= CNT_W'(MUL_LAT - 1);
              state_q  <= S_MUL;
            end else if (is_div) begin
              // A zero divisor retires straight away and leaves HI/LO alone.
              if (md.src_b == '0) begin
                state_q <= S_DONE;
              end else begin
                op_a_q    <= abs_a;
                op_b_q    <= abs_b;
                rem_q     <= '0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                cnt_q     <= CNT_W'(DATA_W - 1);
                state_q   <= S_DIV;
              end
            end else if (md.alucontrol == ALU_MTHI) begin
              hi_q <= md.src_a;
            end else if (md.alucontrol == ALU_MTLO) begin
              lo_q <= md.src_a;
            end
          end
        end
        S_MUL: begin
          if (md.flush) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            {hi_q, lo_q} <= prod;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (md.flush) begin
            state_q <= S_IDLE;
          end else begin
            op_a_q <= quo_d;
            rem_q  <= rem_d;
            if (cnt_q == '0) begin
              lo_q    <= quo_fix;
              hi_q    <= rem_fix;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit. A cycle-level reference model, built from plain arithmetic, is compared with the DUT on every cycle.
// Directed cases pin literal results. Randomized op streams follow them.
module tb_hilo_muldiv_unit;
  localparam int         DATA_W    = 32;
  localparam int         MUL_LAT   = 2;
  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MTHI  = 5'd20;
  localparam logic [4:0] ALU_MTLO  = 5'd21;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  hilo_muldiv_if #(.DATA_W(DATA_W)) md_if ();

  hilo_muldiv_unit #(
    .DATA_W(DATA_W), .MUL_LAT(MUL_LAT),
    .ALU_MULT(ALU_MULT), .ALU_MULTU(ALU_MULTU), .ALU_DIV(ALU_DIV),
    .ALU_DIVU(ALU_DIVU), .ALU_MTHI(ALU_MTHI), .ALU_MTLO(ALU_MTLO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .md(md_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: architectural HI/LO plus remaining busy cycles
  function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      ALU_MULT:  res = 64'(sa * sb);
      ALU_MULTU: res = {32'b0, a} * {32'b0, b};
      ALU_DIV: begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      ALU_DIVU:  res = {a % b, a / b};
      default:   res = '0;
    endcase
    return res;
  endfunction

  function automatic bit is_md(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  int          m_busy;
  bit          m_done;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_rhi  <= '0;
      m_rlo  <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy > 0) begin
      if (md_if.flush) m_busy <= 0;
      else if (m_busy == 1) begin
        m_hi   <= m_rhi;
        m_lo   <= m_rlo;
        m_done <= 1'b1;
        m_busy <= 0;
      end else m_busy <= m_busy - 1;
    end else if (md_if.start && !md_if.flush) begin
      case (md_if.alucontrol)
        ALU_MULT, ALU_MULTU: begin
          {m_rhi, m_rlo} <= ref_result(md_if.alucontrol, md_if.src_a, md_if.src_b);
          m_busy         <= MUL_LAT;
        end
        ALU_DIV, ALU_DIVU: begin
          if (md_if.src_b == 32'd0) m_done <= 1'b1;
          else begin
            {m_rhi, m_rlo} <= ref_result(md_if.alucontrol, md_if.src_a, md_if.src_b);
            m_busy         <= DATA_W;
          end
        end
        ALU_MTHI: m_hi <= md_if.src_a;
        ALU_MTLO: m_lo <= md_if.src_a;
        default: ;
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = resetn && ((m_busy > 0) ||
                (!m_done && is_md(md_if.alucontrol) && md_if.start && !md_if.flush));
    check("cyc_stall", 64'(md_if.stall), 64'(exp_stall));
    check("cyc_done",  64'(md_if.done),  64'(m_done));
    check("cyc_hi",    64'(md_if.hi_o),  64'(m_hi));
    check("cyc_lo",    64'(md_if.lo_o),  64'(m_lo));
  end

  // driver: hold the op until the unit retires it (done), a flush kills it, or it never stalls
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int nstall, output int ndone);
    bit fin;
    bit stl;
    nstall = 0;
    ndone  = 0;
    fin    = 1'b0;
    @(posedge clk); #1;
    md_if.start      = 1'b1;
    md_if.alucontrol = op;
    md_if.src_a      = a;
    md_if.src_b      = b;
    md_if.flush      = 1'b0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      if (c == flush_at) md_if.flush = 1'b1;
      @(negedge clk);
      stl = md_if.stall;
      if (stl) nstall++;
      if (md_if.done) ndone++;
      if (md_if.flush || !stl) fin = 1'b1;
      @(posedge clk); #1;
      md_if.flush = 1'b0;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL run_op_timeout: op %0d still stalling after 60 cycles", op);
    end
    md_if.start      = 1'b0;
    md_if.alucontrol = 5'd0;
    repeat (2) begin
      @(negedge clk);
      if (md_if.done)  ndone++;
      if (md_if.stall) nstall++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          ns, nd, fl, sel;
    logic [4:0]  op;
    logic [31:0] a, b;
    bit          saw_stall;

    resetn           = 1'b0;
    md_if.start      = 1'b0;
    md_if.alucontrol = 5'd0;
    md_if.flush      = 1'b0;
    md_if.src_a      = '0;
    md_if.src_b      = '0;
    #12;
    check("reset_stall", 64'(md_if.stall), 64'd0);
    check("reset_done",  64'(md_if.done),  64'd0);
    check("reset_hi",    64'(md_if.hi_o),  64'd0);
    check("reset_lo",    64'(md_if.lo_o),  64'd0);
    check("reset_state", 64'(md_if.state_dbg), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // 1: multiply
    run_op(ALU_MULT, 32'hFFFFFFFF, 32'd2, 0, ns, nd);
    check("mult_stall", 64'(ns), 64'd3);
    check("mult_done",  64'(nd), 64'd1);
    check("mult_hilo",  {md_if.hi_o, md_if.lo_o}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(ALU_MULTU, 32'hFFFFFFFF, 32'd2, 0, ns, nd);
    check("multu_stall", 64'(ns), 64'd3);
    check("multu_done",  64'(nd), 64'd1);
    check("multu_hilo",  {md_if.hi_o, md_if.lo_o}, 64'h00000001_FFFFFFFE);

    // 2: divide, with start held through DONE
    run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, 0, ns, nd);
    check("div_stall", 64'(ns), 64'd33);
    check("div_done",  64'(nd), 64'd1);
    check("div_hilo",  {md_if.hi_o, md_if.lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(ALU_DIVU, 32'd7, 32'd2, 0, ns, nd);
    check("divu_stall", 64'(ns), 64'd33);
    check("divu_hilo",  {md_if.hi_o, md_if.lo_o}, 64'h00000001_00000003);

    // 3: divide by zero, then the overflow corner
    run_op(ALU_MTHI, 32'hAA, 32'd0, 0, ns, nd);
    run_op(ALU_MTLO, 32'hBB, 32'd0, 0, ns, nd);
    run_op(ALU_DIV, 32'd5, 32'd0, 0, ns, nd);
    check("div0_stall", 64'(ns), 64'd1);
    check("div0_done",  64'(nd), 64'd1);
    check("div0_hilo",  {md_if.hi_o, md_if.lo_o}, 64'h000000AA_000000BB);
    run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, ns, nd);
    check("divovf_hilo", {md_if.hi_o, md_if.lo_o}, 64'h00000000_80000000);

    // 4: back-to-back MTHI/MTLO
    saw_stall = 1'b0;
    @(posedge clk); #1;
    md_if.start = 1'b1; md_if.alucontrol = ALU_MTHI; md_if.src_a = 32'h12345678;
    @(negedge clk); saw_stall |= md_if.stall;
    @(posedge clk); #1;
    md_if.alucontrol = ALU_MTLO; md_if.src_a = 32'h9;
    @(negedge clk); saw_stall |= md_if.stall;
    @(posedge clk); #1;
    md_if.start = 1'b0; md_if.alucontrol = 5'd0;
    @(negedge clk);
    check("mt_stall", 64'(saw_stall), 64'd0);
    check("mt_hilo",  {md_if.hi_o, md_if.lo_o}, 64'h12345678_00000009);

    // 5: flush on the 10th DIV cycle and on the final DIV cycle
    run_op(ALU_DIVU, 32'd1000, 32'd7, 11, ns, nd);
    check("flush10_stall", 64'(ns), 64'd11);
    check("flush10_done",  64'(nd), 64'd0);
    check("flush10_hilo",  {md_if.hi_o, md_if.lo_o}, 64'h12345678_00000009);
    run_op(ALU_DIV, 32'd1000, 32'd7, 33, ns, nd);
    check("flushlast_done", 64'(nd), 64'd0);
    check("flushlast_hilo", {md_if.hi_o, md_if.lo_o}, 64'h12345678_00000009);

    // 6: reset in the middle of a multiply
    @(posedge clk); #1;
    md_if.start = 1'b1; md_if.alucontrol = ALU_MULT;
    md_if.src_a = 32'd100; md_if.src_b = 32'd100;
    @(posedge clk); #1;
    resetn = 1'b0;
    md_if.start = 1'b0; md_if.alucontrol = 5'd0;
    #1;
    check("rst_mid_stall", 64'(md_if.stall), 64'd0);
    check("rst_mid_done",  64'(md_if.done),  64'd0);
    check("rst_mid_hilo",  {md_if.hi_o, md_if.lo_o}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op(ALU_MULT, 32'd3, 32'd5, 0, ns, nd);
    check("post_rst_done", 64'(nd), 64'd1);
    check("post_rst_hilo", {md_if.hi_o, md_if.lo_o}, 64'd15);

    // randomized op stream
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: op = ALU_MULT;
        1: op = ALU_MULTU;
        2: op = ALU_DIV;
        3: op = ALU_DIVU;
        4: op = ALU_MTHI;
        5: op = ALU_MTLO;
        6: op = 5'($urandom_range(0, 15));
        default: op = 5'($urandom_range(22, 31));
      endcase
      sel = $urandom_range(0, 7);
      a   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: b = $urandom;
      endcase
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 36) : 0;
      run_op(op, a, b, fl, ns, nd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
